// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, FSM state types and address/response helpers for the
// SRAM-backed AXI slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RD,
        R_OUT
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    function automatic logic [31:0] axi_next_addr(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] res;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP:  res = (addr & ~mask) | ((addr + step) & mask);
            default:     res = addr + step;
        endcase
        return res;
    endfunction

    // Address decode wins over protocol errors when both apply.
    function automatic logic [1:0] axi_check_req(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned mem_aw,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        if ((addr >> (mem_aw + 2)) != (base >> (mem_aw + 2)))
            return RESP_DECERR;
        else if ((size > 3'd2) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok))
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// One-read one-write word SRAM with byte write enables and registered read
// data; a same-cycle read and write of one word returns the old contents.
module sram_1r1w #(
    parameter int unsigned MEM_AW = 14
) (
    input  logic              i_clk,
    input  logic              i_re,
    input  logic [MEM_AW-1:0] i_raddr,
    output logic [31:0]       o_rdata,
    input  logic              i_we,
    input  logic [MEM_AW-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wbe
);

    logic [31:0] r_mem [0:(1 << MEM_AW) - 1];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_re)
            r_rdata <= r_mem[i_raddr];
        if (i_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_wbe[b])
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave terminating the core's master port onto a word-addressed SRAM,
// with independent read and write burst engines.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MEM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic [1:0]      arlock,
    input  logic [3:0]      arcache,
    input  logic [2:0]      arprot,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic [1:0]      awlock,
    input  logic [3:0]      awcache,
    input  logic [2:0]      awprot,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    logic w_unused;
    assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    rd_state_e       r_rstate, w_rstate_nxt;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_raddr;
    logic [7:0]      r_rlen;
    logic [7:0]      r_rcnt;
    logic [2:0]      r_rsize;
    logic [1:0]      r_rburst;
    logic [1:0]      r_rresp;
    logic            r_rdata_ok;
    logic            w_sram_re;
    logic [31:0]     w_sram_rdata;

    wr_state_e       r_wstate, w_wstate_nxt;
    logic [ID_W-1:0] r_wid;
    logic [31:0]     r_waddr;
    logic [7:0]      r_wlen;
    logic [7:0]      r_wcnt;
    logic [2:0]      r_wsize;
    logic [1:0]      r_wburst;
    logic [1:0]      r_wresp;
    logic            w_sram_we;

    sram_1r1w #(
        .MEM_AW (MEM_AW)
    ) u_sram (
        .i_clk   (aclk),
        .i_re    (w_sram_re),
        .i_raddr (r_raddr[MEM_AW+1:2]),
        .o_rdata (w_sram_rdata),
        .i_we    (w_sram_we),
        .i_waddr (r_waddr[MEM_AW+1:2]),
        .i_wdata (wdata),
        .i_wbe   (wstrb)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rlast        = 1'b0;
        w_sram_re    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid)
                    w_rstate_nxt = R_RD;
            end
            R_RD: begin
                w_sram_re    = (r_rresp == RESP_OKAY);
                w_rstate_nxt = R_OUT;
            end
            R_OUT: begin
                rvalid = 1'b1;
                rlast  = (r_rcnt == 8'd0);
                if (rready)
                    w_rstate_nxt = (r_rcnt == 8'd0) ? R_IDLE : R_RD;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rid      <= '0;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rcnt     <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
            r_rresp    <= RESP_OKAY;
            r_rdata_ok <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_rid      <= arid;
                        r_raddr    <= araddr;
                        r_rlen     <= arlen;
                        r_rcnt     <= arlen;
                        r_rsize    <= arsize;
                        r_rburst   <= arburst;
                        r_rresp    <= axi_check_req(araddr, BASE_ADDR, MEM_AW, arsize, arlen, arburst);
                        r_rdata_ok <= 1'b0;
                    end
                end
                R_RD: r_rdata_ok <= (r_rresp == RESP_OKAY);
                R_OUT: begin
                    if (rready && (r_rcnt != 8'd0)) begin
                        r_raddr <= axi_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
                        r_rcnt  <= r_rcnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Error beats never touch the SRAM, so their data is forced to zero here.
    assign rdata = r_rdata_ok ? w_sram_rdata : '0;
    assign rid   = r_rid;
    assign rresp = r_rresp;

    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        w_sram_we    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid)
                    w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    w_sram_we = (r_wresp == RESP_OKAY);
                    if (wlast || (r_wcnt == 8'd0))
                        w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready)
                    w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        r_wid    <= awid;
                        r_waddr  <= awaddr;
                        r_wlen   <= awlen;
                        r_wcnt   <= awlen;
                        r_wsize  <= awsize;
                        r_wburst <= awburst;
                        r_wresp  <= axi_check_req(awaddr, BASE_ADDR, MEM_AW, awsize, awlen, awburst);
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        r_waddr <= axi_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
                        r_wcnt  <= r_wcnt - 8'd1;
                        // wlast disagreeing with the beat count flags the burst unless it already errored
                        if ((wlast != (r_wcnt == 8'd0)) && (r_wresp == RESP_OKAY))
                            r_wresp <= RESP_SLVERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bid   = r_wid;
    assign bresp = r_wresp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a byte-level memory model predicts every
// R and B beat, and a compare process checks the DUT against it each cycle.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 aclk = ~aclk;

    axi_sram_slave #(
        .ID_W      (4),
        .MEM_AW    (14),
        .BASE_ADDR (32'h1fc0_0000)
    ) dut (
        .aclk    (aclk),    .aresetn (aresetn),
        .arid    (arid),    .araddr  (araddr),  .arlen   (arlen),   .arsize  (arsize),
        .arburst (arburst), .arlock  (arlock),  .arcache (arcache), .arprot  (arprot),
        .arvalid (arvalid), .arready (arready),
        .rid     (rid),     .rdata   (rdata),   .rresp   (rresp),   .rlast   (rlast),
        .rvalid  (rvalid),  .rready  (rready),
        .awid    (awid),    .awaddr  (awaddr),  .awlen   (awlen),   .awsize  (awsize),
        .awburst (awburst), .awlock  (awlock),  .awcache (awcache), .awprot  (awprot),
        .awvalid (awvalid), .awready (awready),
        .wid     (wid),     .wdata   (wdata),   .wstrb   (wstrb),   .wlast   (wlast),
        .wvalid  (wvalid),  .wready  (wready),
        .bid     (bid),     .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        bit          chk_data;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    int          checks = 0;
    int          errors = 0;
    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] mem[int];
    logic [31:0] wd[16];
    logic [3:0]  ws[16];
    logic [31:0] rd_log[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response classification straight from the address map and burst rules.
    function automatic logic [1:0] m_resp(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
        if (a / 32'h10000 != 32'h1fc0) return 2'b11;
        if (size > 2 || burst == 3) return 2'b10;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
        return 2'b00;
    endfunction

    // Byte address of beat i, computed directly rather than by stepping.
    function automatic logic [31:0] m_addr(input logic [31:0] start, input int i, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
        int unsigned bytes, total, lo;
        bytes = 1 << size;
        if (burst == 0) return start;
        if (burst == 1) return start + i * bytes;
        total = (int'(len) + 1) * bytes;
        lo = start - (start % total);
        return lo + ((start - lo + i * bytes) % total);
    endfunction

    function automatic int m_widx(input logic [31:0] a);
        return int'((a % 32'h10000) / 4);
    endfunction

    function automatic logic [31:0] m_read(input int w);
        return mem.exists(w) ? mem[w] : 32'hxxxx_xxxx;
    endfunction

    always @(negedge aclk) begin
        if (aresetn) begin
            if (rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", rvalid, 0);
                else begin
                    chk("rid", rid, exp_r[0].id);
                    chk("rresp", rresp, exp_r[0].resp);
                    chk("rlast", rlast, exp_r[0].last);
                    if (exp_r[0].chk_data) chk("rdata", rdata, exp_r[0].data);
                    if (rready) exp_r.delete(0);
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", bvalid, 0);
                else begin
                    chk("bid", bid, exp_b[0].id);
                    chk("bresp", bresp, exp_b[0].resp);
                    if (bready) exp_b.delete(0);
                end
            end
        end
    end

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_n);
        logic [1:0] resp;
        rbeat_t     e;
        int         hs, stalled;
        bit         got;
        resp = m_resp(addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            e.id       = id;
            e.resp     = resp;
            e.last     = (i == int'(len));
            e.chk_data = (resp != 2'b10);
            e.data     = (resp == 2'b00) ? m_read(m_widx(m_addr(addr, i, len, size, burst))) : 32'h0;
            exp_r.push_back(e);
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge aclk);
            if (arready) got = 1;
        end
        if (!got) chk("ar_timeout", arready, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        hs = 0; stalled = 0;
        rready = (stall_beat != 0);
        for (int c = 0; c < 500 && hs <= int'(len); c++) begin
            @(negedge aclk);
            if (rvalid && rready) begin
                rd_log[hs] = rdata;
                hs++;
            end else if (rvalid) stalled++;
            @(posedge aclk); #1;
            rready = !(hs == stall_beat && stalled < stall_n);
        end
        if (hs <= int'(len)) begin
            chk("r_timeout", hs, int'(len) + 1);
            exp_r.delete();
        end
        rready = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_pos, input int abort_after);
        logic [1:0]  resp, fresp;
        logic [31:0] w;
        bexp_t       e;
        int          nb, wi;
        bit          got;
        resp  = m_resp(addr, len, size, burst);
        nb    = (wlast_pos < int'(len)) ? wlast_pos + 1 : int'(len) + 1;
        fresp = (resp != 2'b00) ? resp : ((wlast_pos != int'(len)) ? 2'b10 : 2'b00);
        e.id = id; e.resp = fresp;
        if (abort_after < 0) exp_b.push_back(e);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge aclk);
            if (awready) got = 1;
        end
        if (!got) chk("aw_timeout", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b == abort_after) return;
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_pos); wvalid = 1'b1;
            got = 0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge aclk);
                if (wready) got = 1;
            end
            if (!got) begin
                chk("w_timeout", wready, 1);
                wvalid = 1'b0;
                exp_b.delete();
                return;
            end
            if (resp == 2'b00) begin
                wi = m_widx(m_addr(addr, b, len, size, burst));
                w  = m_read(wi);
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) w[k*8 +: 8] = wd[b][k*8 +: 8];
                mem[wi] = w;
            end
            @(posedge aclk); #1;
            wvalid = 1'b0; wlast = 1'b0;
        end
        for (int c = 0; c < 100 && exp_b.size() != 0; c++) @(negedge aclk);
        if (exp_b.size() != 0) begin
            chk("b_timeout", bvalid, 1);
            exp_b.delete();
        end
        @(posedge aclk); #1;
    endtask

    task automatic apply_reset();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        exp_r.delete();
        exp_b.delete();
        @(negedge aclk);
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge aclk); #1;
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 16; i++) begin
            wd[i] = base + step * i;
            ws[i] = 4'hf;
        end
    endtask

    initial begin
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;

        apply_reset();

        fill(32'hdeadbeef, 0);
        do_write(4'h3, 32'h1fc0_0010, 8'd0, 3'd2, 2'b01, 0, -1);
        do_read(4'h5, 32'h1fc0_0010, 8'd0, 3'd2, 2'b01, -1, 0);
        chk("pin_single", rd_log[0], 32'hdeadbeef);

        fill(32'h0, 32'h11111111);
        do_write(4'h7, 32'h1fc0_0100, 8'd7, 3'd2, 2'b01, 7, -1);
        do_read(4'h8, 32'h1fc0_0100, 8'd7, 3'd2, 2'b01, -1, 0);
        chk("pin_incr7", rd_log[7], 32'h77777777);

        do_read(4'h9, 32'h1fc0_0108, 8'd3, 3'd2, 2'b10, -1, 0);
        chk("pin_wrap0", rd_log[0], 32'h22222222);
        chk("pin_wrap1", rd_log[1], 32'h33333333);
        chk("pin_wrap2", rd_log[2], 32'h00000000);
        chk("pin_wrap3", rd_log[3], 32'h11111111);

        fill(32'h11223344, 0);
        do_write(4'h1, 32'h1fc0_0200, 8'd0, 3'd2, 2'b01, 0, -1);
        wd[0] = 32'h0000ab00; ws[0] = 4'b0010;
        do_write(4'h2, 32'h1fc0_0200, 8'd0, 3'd0, 2'b01, 0, -1);
        do_read(4'h2, 32'h1fc0_0200, 8'd0, 3'd2, 2'b01, -1, 0);
        chk("pin_strb", rd_log[0], 32'h1122ab44);

        fill(32'h5a5a5a5a, 0);
        do_write(4'h4, 32'h1fc0_0000, 8'd0, 3'd2, 2'b01, 0, -1);
        do_read(4'ha, 32'h0000_0000, 8'd3, 3'd2, 2'b01, -1, 0);
        fill(32'hffffffff, 0);
        do_write(4'hb, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 0, -1);
        do_read(4'hc, 32'h1fc0_0000, 8'd0, 3'd2, 2'b01, -1, 0);
        chk("pin_decerr_keep", rd_log[0], 32'h5a5a5a5a);

        do_read(4'hd, 32'h1fc0_0100, 8'd1, 3'd3, 2'b01, -1, 0);
        fill(32'h01010101, 1);
        do_write(4'he, 32'h1fc0_0400, 8'd2, 3'd2, 2'b10, 2, -1);
        fill(32'h50000000, 1);
        do_write(4'h6, 32'h1fc0_0500, 8'd3, 3'd2, 2'b01, 1, -1);
        do_read(4'h6, 32'h1fc0_0500, 8'd1, 3'd2, 2'b01, -1, 0);
        fill(32'h60000000, 1);
        do_write(4'hf, 32'h1fc0_0600, 8'd1, 3'd2, 2'b01, 99, -1);
        do_read(4'hf, 32'h1fc0_0600, 8'd1, 3'd2, 2'b01, -1, 0);
        fill(32'hc0000000, 1);
        do_write(4'h0, 32'h1fc0_0700, 8'd3, 3'd2, 2'b00, 3, -1);
        do_read(4'h0, 32'h1fc0_0700, 8'd2, 3'd2, 2'b00, -1, 0);
        chk("pin_fixed", rd_log[2], 32'hc0000003);

        do_read(4'h9, 32'h1fc0_0100, 8'd7, 3'd2, 2'b01, 3, 5);
        chk("pin_stall", rd_log[3], 32'h33333333);

        fill(32'ha0a0a0a0, 1);
        do_write(4'h1, 32'h1fc0_0300, 8'd3, 3'd2, 2'b01, 3, -1);
        fill(32'hb0b0b0b0, 1);
        do_write(4'h2, 32'h1fc0_0300, 8'd3, 3'd2, 2'b01, 3, 2);
        apply_reset();
        do_read(4'h3, 32'h1fc0_0300, 8'd3, 3'd2, 2'b01, -1, 0);
        chk("pin_rst_kept0", rd_log[0], 32'hb0b0b0b0);
        chk("pin_rst_kept2", rd_log[2], 32'ha0a0a0a2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
